// File: rtl/uart_pkg.sv
// uart_pkg: state encodings, parameter limits and parity helper
// shared by the UART transmit and receive blocks.
package uart_pkg;

    // Three-bit state encodings, common to uart_tx and uart_rx.
    typedef enum logic [2:0] {
        SM_IDLE      = 3'd0,
        SM_TX_START  = 3'd1,
        SM_TX_DATA   = 3'd2,
        SM_TX_PARITY = 3'd3,
        SM_TX_STOP   = 3'd4
    } sm_state_t;

    localparam int DATA_BITS_MIN        = 5;
    localparam int DATA_BITS_MAX        = 9;
    localparam int DATA_BITS_MAX_PARITY = 8;
    localparam int STOP_BITS_MIN        = 1;
    localparam int STOP_BITS_MAX        = 2;
    localparam int PARITY_BITS_MAX      = 1;
    localparam int CLK_PER_BIT_MIN      = 2;
    localparam int WORD_MAX             = 9;

    // Even parity is the XOR of all bits; odd parity is its inverse.
    function automatic logic parity_bit(
        input logic [WORD_MAX-1:0] word,
        input logic                odd
    );
        return (^word) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: divides clk down to one bit_end pulse every
// CLK_PER_BIT cycles; clear holds the count at zero.
module uart_bit_timer #(
    parameter int CLK_PER_BIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);

    logic [CW-1:0] count;

    assign bit_end = (count == LAST);

    // Count up, wrapping explicitly at the last cycle of each bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || bit_end) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: valid/ready fed asynchronous serial transmitter,
// start + data (LSB first) + optional parity + stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BIT_COUNT   = 8,
    parameter int PARITY_BIT_COUNT = 0,
    parameter int PARITY_ODD       = 0,
    parameter int STOP_BIT_COUNT   = 1,
    parameter int CLK_PER_BIT      = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_BIT_COUNT-1:0] data,
    input  logic                      valid,
    output logic                      ready,
    output logic                      serial,
    output logic                      busy,
    output logic                      done
);

    localparam logic [3:0] LAST_DATA = 4'(DATA_BIT_COUNT - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BIT_COUNT - 1);
    localparam logic       ODD       = (PARITY_ODD != 0);

    generate
        if (DATA_BIT_COUNT < DATA_BITS_MIN ||
            DATA_BIT_COUNT > DATA_BITS_MAX) begin : g_bad_data
            $error("uart_tx: DATA_BIT_COUNT out of range");
        end
        if (PARITY_BIT_COUNT < 0 ||
            PARITY_BIT_COUNT > PARITY_BITS_MAX) begin : g_bad_par
            $error("uart_tx: PARITY_BIT_COUNT must be 0 or 1");
        end
        if (PARITY_BIT_COUNT == 1 &&
            DATA_BIT_COUNT > DATA_BITS_MAX_PARITY) begin : g_bad_dpar
            $error("uart_tx: too many data bits for a parity frame");
        end
        if (STOP_BIT_COUNT < STOP_BITS_MIN ||
            STOP_BIT_COUNT > STOP_BITS_MAX) begin : g_bad_stop
            $error("uart_tx: STOP_BIT_COUNT must be 1 or 2");
        end
        if (CLK_PER_BIT < CLK_PER_BIT_MIN) begin : g_bad_cpb
            $error("uart_tx: CLK_PER_BIT must be at least 2");
        end
    endgenerate

    sm_state_t                 state;
    logic [3:0]                bit_cnt;
    logic [DATA_BIT_COUNT-1:0] shift_reg;
    logic                      par_q;
    logic                      serial_q;
    logic                      bit_end;
    logic                      last_stop;
    logic                      accept;
    logic                      data_par;

    uart_bit_timer #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == SM_IDLE),
        .bit_end(bit_end)
    );

    assign last_stop = (state == SM_TX_STOP) &&
                       (bit_cnt == LAST_STOP) && bit_end;
    assign ready     = (state == SM_IDLE) || last_stop;
    assign accept    = valid && ready;
    assign busy      = (state != SM_IDLE);
    assign done      = last_stop;
    assign serial    = serial_q;
    assign data_par  = parity_bit(WORD_MAX'(data), ODD);

    // Frame sequencer; serial_q is loaded with the level of the
    // state being entered so the line changes right at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SM_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_q     <= 1'b0;
            serial_q  <= 1'b1;
        end else begin
            unique case (state)
                SM_IDLE: begin
                    serial_q <= 1'b1;
                    if (accept) begin
                        shift_reg <= data;
                        par_q     <= data_par;
                        bit_cnt   <= '0;
                        serial_q  <= 1'b0;
                        state     <= SM_TX_START;
                    end
                end
                SM_TX_START: begin
                    if (bit_end) begin
                        bit_cnt  <= '0;
                        serial_q <= shift_reg[0];
                        state    <= SM_TX_DATA;
                    end
                end
                SM_TX_DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            if (PARITY_BIT_COUNT == 1) begin
                                serial_q <= par_q;
                                state    <= SM_TX_PARITY;
                            end else begin
                                serial_q <= 1'b1;
                                state    <= SM_TX_STOP;
                            end
                        end else begin
                            shift_reg <= shift_reg >> 1;
                            serial_q  <= shift_reg[1];
                            bit_cnt   <= bit_cnt + 4'd1;
                        end
                    end
                end
                SM_TX_PARITY: begin
                    if (bit_end) begin
                        bit_cnt  <= '0;
                        serial_q <= 1'b1;
                        state    <= SM_TX_STOP;
                    end
                end
                SM_TX_STOP: begin
                    if (bit_end) begin
                        if (bit_cnt == LAST_STOP) begin
                            bit_cnt <= '0;
                            if (accept) begin
                                shift_reg <= data;
                                par_q     <= data_par;
                                serial_q  <= 1'b0;
                                state     <= SM_TX_START;
                            end else begin
                                serial_q <= 1'b1;
                                state    <= SM_IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    bit_cnt  <= '0;
                    serial_q <= 1'b1;
                    state    <= SM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three uart_tx configurations driven with directed and
// random words; a line-level frame model checks every cycle.
module tb_uart_tx;

    localparam int NCFG = 3;
    localparam int CFG_D [NCFG] = '{8, 8, 7};
    localparam int CFG_P [NCFG] = '{0, 1, 1};
    localparam int CFG_O [NCFG] = '{0, 0, 1};
    localparam int CFG_S [NCFG] = '{1, 1, 2};
    localparam int CFG_C [NCFG] = '{8, 3, 5};

    typedef struct packed {
        int         start;
        logic [8:0] word;
    } frm_t;

    logic clk;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int D  = CFG_D[g];
        localparam int P  = CFG_P[g];
        localparam int O  = CFG_O[g];
        localparam int S  = CFG_S[g];
        localparam int C  = CFG_C[g];
        localparam int FL = C * (1 + D + P + S);

        logic         rst_n;
        logic         valid;
        logic [D-1:0] data;
        logic         ready;
        logic         serial;
        logic         busy;
        logic         done;
        logic         fin = 1'b0;
        int           cyc = 0;
        int           frames_done = 0;
        frm_t         q[$];
        logic [3:0]   exp_v;
        logic [3:0]   act_v;
        int           pos;

        uart_tx #(
            .DATA_BIT_COUNT  (D),
            .PARITY_BIT_COUNT(P),
            .PARITY_ODD      (O),
            .STOP_BIT_COUNT  (S),
            .CLK_PER_BIT     (C)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .data  (data),
            .valid (valid),
            .ready (ready),
            .serial(serial),
            .busy  (busy),
            .done  (done)
        );

        // Level of frame bit k: start, data LSB first, parity, stops.
        function automatic logic frame_bit(input logic [8:0] w,
                                           input int k);
            if (k == 0) return 1'b0;
            if (k <= D) return w[k-1];
            if (P == 1 && k == D + 1) return (^w) ^ (O != 0);
            return 1'b1;
        endfunction

        // Expected {serial,busy,done,ready} for this cycle.
        always @(negedge clk) begin
            if (!rst_n) begin
                q.delete();
                exp_v = 4'b1001;
            end else if (q.size() > 0 && cyc >= q[0].start) begin
                pos = cyc - q[0].start;
                exp_v = {frame_bit(q[0].word, pos / C), 1'b1,
                         pos == FL - 1, pos == FL - 1};
                if (pos == FL - 1) begin
                    void'(q.pop_front());
                    frames_done++;
                end
            end else begin
                exp_v = 4'b1001;
            end
            act_v = {serial, busy, done, ready};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cfg%0d line cyc=%0d {serial,busy,done,ready} got=%b exp=%b",
                         g, cyc, act_v, exp_v);
            end
            if (rst_n && valid && exp_v[0])
                q.push_back('{start: cyc + 1, word: 9'(data)});
            cyc++;
        end

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        task automatic idle(input int n);
            repeat (n) step();
        endtask

        task automatic send(input logic [8:0] w, input bit hold);
            int n;
            n = 0;
            data  = D'(w);
            valid = 1'b1;
            @(negedge clk);
            while (!ready && n < 4 * FL) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n >= 4 * FL) begin
                errors++;
                $display("FAIL cfg%0d send_timeout word=%h got=no_ready exp=ready",
                         g, w);
            end
            step();
            if (!hold) valid = 1'b0;
        endtask

        initial begin
            int base;
            rst_n = 1'b0;
            valid = 1'b0;
            data  = '0;
            idle(3);
            rst_n = 1'b1;
            idle(3);

            send(9'h055, 1'b0);
            idle(FL + 5);

            send(9'h0A5, 1'b1);
            send(9'h03C, 1'b0);
            idle(FL + 5);

            send(9'h007, 1'b0);
            idle(FL + 5);

            send(9'h0FF, 1'b0);
            idle(FL + 5);

            send(9'h000, 1'b0);
            idle(4 * C + C / 2);
            checks++;
            if (serial !== 1'b0) begin
                errors++;
                $display("FAIL cfg%0d pre_reset_bit3 got=%b exp=0", g, serial);
            end
            #2 rst_n = 1'b0;
            #1;
            checks++;
            if (serial !== 1'b1) begin
                errors++;
                $display("FAIL cfg%0d async_reset_serial got=%b exp=1", g, serial);
            end
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            idle(2);

            send(9'h081, 1'b0);
            idle(FL + 5);

            base = frames_done;
            for (int i = 0; i < 256; i++) send(9'(i), 1'b1);
            valid = 1'b0;
            idle(FL + 5);
            checks++;
            if (frames_done - base != 256) begin
                errors++;
                $display("FAIL cfg%0d loopback_frames got=%0d exp=256",
                         g, frames_done - base);
            end

            repeat (1500) begin
                valid = ($urandom_range(2) != 0);
                data  = D'($urandom);
                step();
            end
            valid = 1'b0;
            idle(FL + 5);
            fin = 1'b1;
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin) &&
               n < 90000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin)) begin
            errors++;
            $display("FAIL run_timeout got=%0d cycles exp=all configs finished", n);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter, the transmit-side counterpart of the team's uart_rx, with matching frame format and parameter set.
- Accepts parallel words through a valid/ready handshake and drives an idle-high asynchronous serial line: start bit, DATA_BIT_COUNT data bits LSB first, optional parity bit, then STOP_BIT_COUNT stop bits.
- Sits between console-mux logic and the TX pin. Its line output is also used as a loopback source for uart_rx in benches.

Parameters:
- DATA_BIT_COUNT, 8: data bits per frame. Legal range 5..9; 5..8 when parity is enabled.
- PARITY_BIT_COUNT, 0: 0 = no parity bit, 1 = one parity bit.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Ignored when PARITY_BIT_COUNT=0.
- STOP_BIT_COUNT, 1: stop bits per frame. Legal values 1 or 2.
- CLK_PER_BIT, 8: clk cycles per serial bit. Must be at least 2.

Ports:
- clk, input, 1: single clock for the whole block.
- rst_n, input, 1: asynchronous, active-low reset.
- data, input, DATA_BIT_COUNT: word to transmit. Sampled only on handshake.
- valid, input, 1: upstream has a word on data.
- ready, output, 1: block accepts a word this cycle.
- serial, output, 1: TX line. Idle high.
- busy, output, 1: a frame is in progress (any state other than SM_IDLE).
- done, output, 1: one-cycle pulse in the final cycle of the last stop bit.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = SM_IDLE, serial = 1, busy = 0, done = 0, ready = 1.
  - Bit counter and clock counter = 0; shift register cleared.
  - Reset asserted mid-frame forces serial = 1 immediately, without waiting for a clock edge. The partial frame is abandoned and not resumed.
- Handshake:
  - A word is accepted on any rising edge where valid && ready. data is captured into an internal shift register on that edge.
  - data and valid are ignored whenever ready = 0. A held valid does not queue a word.
- ready = (state == SM_IDLE) || (state == SM_TX_STOP && last cycle of the last stop bit).
- States and transitions:
  - SM_IDLE: serial = 1. On accept, go to SM_TX_START.
  - SM_TX_START: serial = 0 for CLK_PER_BIT cycles, then go to SM_TX_DATA.
  - SM_TX_DATA: serial = shift_reg[0]. Every CLK_PER_BIT cycles, shift right and increment the bit counter. After DATA_BIT_COUNT bits, go to SM_TX_PARITY if PARITY_BIT_COUNT = 1, otherwise to SM_TX_STOP.
  - SM_TX_PARITY: serial = parity for CLK_PER_BIT cycles, then go to SM_TX_STOP.
  - SM_TX_STOP: serial = 1 for STOP_BIT_COUNT × CLK_PER_BIT cycles. In the final cycle, pulse done. If valid is high in that cycle, go to SM_TX_START with no idle gap; otherwise go to SM_IDLE.
- Parity:
  - Computed once at accept, from the captured word.
  - Even parity: XOR of all data bits. Odd parity: the inverse of that XOR.
- Latency and timing:
  - Accept on edge N causes serial to fall after edge N (start bit begins in cycle N+1).
  - Every bit, including each stop bit, lasts exactly CLK_PER_BIT cycles.
  - Frame length = CLK_PER_BIT × (1 + DATA_BIT_COUNT + PARITY_BIT_COUNT + STOP_BIT_COUNT) cycles.
- Widths:
  - Clock counter: $clog2(CLK_PER_BIT) bits. It wraps to 0 at CLK_PER_BIT-1, never at the natural overflow.
  - Bit counter: 4 bits, shared between data bits and stop bits, and cleared on every state change.
- Output registering: serial is driven from a flop, so it is glitch-free.
- Illegal parameter values are caught by elaboration-time checks (a $error in a generate block). No runtime error state exists.

Decomposition:
- Shared package uart_pkg:
  - SM_* state encodings, 3 bits, shared with uart_rx.
  - Legal-range constants for DATA_BIT_COUNT, STOP_BIT_COUNT and PARITY_BIT_COUNT.
  - A parity function (data, odd) → bit.
- One natural sub-module: uart_bit_timer.
  - Counts clk cycles and pulses bit_end every CLK_PER_BIT cycles.
  - Clear input restarts the count.
  - Reusable by uart_rx.

Test Plan:
- 8N1, CLK_PER_BIT=8, send 0x55 → serial low for 8 cycles, then 1,0,1,0,1,0,1,0 (8 cycles each), then high for 8 cycles. done pulses in cycle 80 after accept; busy is high for exactly 80 cycles.
- valid held high with 0xA5 then 0x3C → the second accept coincides with the first frame's done. The start bit of 0x3C immediately follows the stop bit of 0xA5 with zero idle cycles.
- Even parity: 8E1, send 0x07 → parity bit 1. Odd parity: 8O1, send 0x07 → parity bit 0. Frame length 88 cycles.
- STOP_BIT_COUNT=2, send 0xFF → stop-high period of 16 cycles, then ready rises and done pulses once.
- Assert rst_n low at bit 3 of 0x00 → serial goes to 1 asynchronously before the next clk edge. After release, ready=1 and the next send of 0x81 is a clean, complete frame.
- Loopback into uart_rx (same parameters) with 256 values 0x00..0xFF back-to-back → every received word matches and no frames are lost. Words offered on data while ready=0 are never transmitted.
